// File: rtl/mouse_pkg.sv
// rtl/mouse_pkg.sv - encodings shared by the PS/2 mouse receiver, transmitter and master
package mouse_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_DATA   = 3'd1,
    RX_PARITY = 3'd2,
    RX_STOP   = 3'd3,
    RX_DONE   = 3'd4
  } rx_state_e;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_PARITY = 2'b01;
  localparam logic [1:0] ERR_STOP   = 2'b10;

  localparam logic [7:0] PS2_ACK              = 8'hFA;
  localparam logic [7:0] PS2_SELF_TEST_OK     = 8'hAA;
  localparam logic [7:0] PS2_ENABLE_REPORTING = 8'hF4;
  localparam logic [7:0] PS2_RESET            = 8'hFF;

  // Odd parity over data+parity is expected; a low stop bit is a framing error.
  function automatic logic [1:0] frame_error(input logic [7:0] data, input logic parity,
                                             input logic stop);
    logic [1:0] err;
    err = ERR_NONE;
    if (!(^{data, parity})) err = err | ERR_PARITY;
    if (!stop)              err = err | ERR_STOP;
    return err;
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// rtl/ps2_edge_sync.sv - synchronises the PS/2 lines and strobes on clock falling edges
module ps2_edge_sync (
  input  logic CLK,
  input  logic RESET,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_fall,
  output logic data_sync
);

  logic [1:0] clk_sync_q, clk_sync_d;
  logic [1:0] data_sync_q, data_sync_d;
  logic       clk_prev_q, clk_prev_d;

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
    data_sync_d = {data_sync_q[0], ps2_data_in};
    clk_prev_d  = clk_sync_q[1];
  end

  // Reset to 1 so an idle-high line never produces a spurious edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

  assign clk_fall  = clk_prev_q & ~clk_sync_q[1];
  assign data_sync = data_sync_q[1];

endmodule

// File: rtl/mouse_receiver.sv
// rtl/mouse_receiver.sv - deframes 11-bit PS/2 device-to-host frames into bytes with error codes
module mouse_receiver
  import mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CTR_WIDTH      = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic [7:0] BYTE_READ,
  output logic [1:0] BYTE_ERROR_CODE,
  output logic       BYTE_READY,
  output logic [2:0] RxStateCode
);

  logic clk_fall;
  logic data_sync;

  ps2_edge_sync u_sync (
    .CLK        (CLK),
    .RESET      (RESET),
    .ps2_clk_in (CLK_MOUSE_IN),
    .ps2_data_in(DATA_MOUSE_IN),
    .clk_fall   (clk_fall),
    .data_sync  (data_sync)
  );

  rx_state_e            state_q, state_d;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [CTR_WIDTH-1:0] timeout_q, timeout_d;
  logic                 parity_q, parity_d;
  logic [7:0]           byte_read_q, byte_read_d;
  logic [1:0]           err_q, err_d;
  logic                 in_frame;

  assign in_frame = (state_q == RX_DATA) || (state_q == RX_PARITY) || (state_q == RX_STOP);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    timeout_d   = timeout_q;
    parity_d    = parity_q;
    byte_read_d = byte_read_q;
    err_d       = err_q;

    if (in_frame) timeout_d = clk_fall ? '0 : timeout_q + 1'b1;

    case (state_q)
      RX_IDLE: begin
        if (clk_fall && READ_ENABLE && !data_sync) begin
          state_d   = RX_DATA;
          shift_d   = '0;
          bit_cnt_d = '0;
          timeout_d = '0;
        end
      end
      RX_DATA: begin
        if (clk_fall) begin
          shift_d[bit_cnt_q] = data_sync;
          bit_cnt_d          = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (clk_fall) begin
          parity_d = data_sync;
          state_d  = RX_STOP;
        end
      end
      RX_STOP: begin
        // Outputs are loaded on the way into DONE so they are valid during the pulse.
        if (clk_fall) begin
          byte_read_d = shift_q;
          err_d       = frame_error(shift_q, parity_q, data_sync);
          state_d     = RX_DONE;
        end
      end
      RX_DONE: state_d = RX_IDLE;
      default: state_d = RX_IDLE;
    endcase

    if (in_frame && !clk_fall && timeout_q == CTR_WIDTH'(TIMEOUT_CYCLES - 1)) state_d = RX_IDLE;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= RX_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      timeout_q   <= '0;
      parity_q    <= 1'b0;
      byte_read_q <= '0;
      err_q       <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      timeout_q   <= timeout_d;
      parity_q    <= parity_d;
      byte_read_q <= byte_read_d;
      err_q       <= err_d;
    end
  end

  assign BYTE_READ       = byte_read_q;
  assign BYTE_ERROR_CODE = err_q;
  assign BYTE_READY      = (state_q == RX_DONE);
  assign RxStateCode     = state_q;

endmodule

// File: tb/tb_mouse_receiver.sv
// tb/tb_mouse_receiver.sv - randomized self-checking bench for mouse_receiver
module tb_mouse_receiver;

  localparam int TIMEOUT = 200;
  localparam int HALF    = 20;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       clk_m = 1'b1;
  logic       data_m = 1'b1;
  logic       read_enable = 1'b1;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;
  logic [2:0] RxStateCode;

  int n_checks = 0;
  int n_fail = 0;
  int ready_cnt = 0;
  int exp_ready = 0;
  logic [7:0] last_byte = 8'h00;
  logic [1:0] last_err = 2'b00;

  mouse_receiver #(.TIMEOUT_CYCLES(TIMEOUT), .CTR_WIDTH(16)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .CLK_MOUSE_IN   (clk_m),
    .DATA_MOUSE_IN  (data_m),
    .READ_ENABLE    (read_enable),
    .BYTE_READ      (BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
    .BYTE_READY     (BYTE_READY),
    .RxStateCode    (RxStateCode)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (BYTE_READY === 1'b1) ready_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: data byte as sent; parity error when total ones over data+parity is even.
  function automatic logic [1:0] model_err(input logic [7:0] b, input logic p, input logic s);
    logic pe;
    pe = ($countones({b, p}) % 2) == 0;
    return {~s, pe};
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic p, input logic s,
                            input int nbits, input bit drop_re);
    logic [10:0] bits;
    bit accept;
    bits   = {s, p, b, 1'b0};
    accept = (read_enable == 1'b1) && (nbits == 11);
    for (int i = 0; i < nbits; i++) begin
      @(negedge CLK);
      data_m = bits[i];
      repeat (HALF) @(negedge CLK);
      clk_m = 1'b0;
      if (i == 10 && accept) begin
        exp_ready++;
        last_byte = b;
        last_err  = model_err(b, p, s);
        repeat (2) @(posedge CLK);
        #1 check_eq("ready_early", BYTE_READY, 1'b0);
        @(posedge CLK);
        #1 check_eq("ready_pulse", BYTE_READY, 1'b1);
        check_eq("byte", BYTE_READ, last_byte);
        check_eq("err", BYTE_ERROR_CODE, last_err);
        @(posedge CLK);
        #1 check_eq("ready_one_cycle", BYTE_READY, 1'b0);
      end
      repeat (HALF) @(negedge CLK);
      clk_m = 1'b1;
      if (i == 0 && drop_re) read_enable = 1'b0;
    end
    @(negedge CLK);
    data_m = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    last_byte = 8'h00;
    last_err  = 2'b00;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    logic rp, rs;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check_eq("rst_byte", BYTE_READ, 8'h00);
    check_eq("rst_err", BYTE_ERROR_CODE, 2'b00);
    check_eq("rst_ready", BYTE_READY, 1'b0);
    check_eq("rst_state", RxStateCode, 3'd0);

    send_frame(8'hFA, 1'b1, 1'b1, 11, 1'b0);
    send_frame(8'hAA, 1'b1, 1'b1, 11, 1'b0);
    send_frame(8'h00, 1'b1, 1'b1, 11, 1'b0);
    send_frame(8'hFA, 1'b0, 1'b1, 11, 1'b0);
    send_frame(8'hF4, 1'b0, 1'b0, 11, 1'b0);
    check_eq("count_basic", ready_cnt, exp_ready);

    send_frame(8'hFF, 1'b1, 1'b1, 5, 1'b0);
    check_eq("partial_state", RxStateCode, 3'd1);
    repeat (TIMEOUT + 10) @(negedge CLK);
    check_eq("timeout_state", RxStateCode, 3'd0);
    check_eq("timeout_no_ready", ready_cnt, exp_ready);
    check_eq("timeout_byte_kept", BYTE_READ, last_byte);
    check_eq("timeout_err_kept", BYTE_ERROR_CODE, last_err);
    send_frame(8'h00, 1'b1, 1'b1, 11, 1'b0);

    do_reset();
    read_enable = 1'b0;
    send_frame(8'hFA, 1'b1, 1'b1, 11, 1'b0);
    check_eq("re0_no_ready", ready_cnt, exp_ready);
    check_eq("re0_byte", BYTE_READ, 8'h00);
    check_eq("re0_err", BYTE_ERROR_CODE, 2'b00);
    check_eq("re0_state", RxStateCode, 3'd0);
    read_enable = 1'b1;
    send_frame(8'h5C, 1'b1, 1'b1, 11, 1'b1);
    check_eq("re_drop_count", ready_cnt, exp_ready);
    read_enable = 1'b1;

    send_frame(8'hFA, 1'b1, 1'b1, 6, 1'b0);
    check_eq("pre_reset_state", RxStateCode, 3'd1);
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    check_eq("midrst_byte", BYTE_READ, 8'h00);
    check_eq("midrst_err", BYTE_ERROR_CODE, 2'b00);
    check_eq("midrst_ready", BYTE_READY, 1'b0);
    check_eq("midrst_state", RxStateCode, 3'd0);
    @(negedge CLK);
    RESET = 1'b0;
    last_byte = 8'h00;
    last_err  = 2'b00;
    repeat (2) @(negedge CLK);
    send_frame(8'hAA, 1'b1, 1'b1, 11, 1'b0);

    for (int k = 0; k < 12; k++) begin
      rb = 8'($urandom_range(0, 255));
      rp = ~(^rb) ^ ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rb, rp, rs, 11, 1'b0);
    end
    check_eq("count_final", ready_cnt, exp_ready);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mouse_receiver.md
Name: mouse_receiver

Overview:
PS/2 device-to-host byte receiver that feeds the mouse master state machine. It samples the mouse clock and data lines and deframes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop). It presents each byte with an error code and a one-cycle BYTE_READY pulse. Capture is gated by the master's READ_ENABLE level.

Parameters:
TIMEOUT_CYCLES, 50000, system-clock cycles allowed between consecutive mouse-clock falling edges inside a frame before the frame is aborted (0.5 ms at 100 MHz).
CTR_WIDTH, 16, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
CLK  input  1  system clock, 100 MHz
RESET  input  1  asynchronous, active-high reset
CLK_MOUSE_IN  input  1  raw PS/2 clock line, asynchronous to CLK
DATA_MOUSE_IN  input  1  raw PS/2 data line, asynchronous to CLK
READ_ENABLE  input  1  level; frames may start only while high
BYTE_READ  output  8  last received data byte
BYTE_ERROR_CODE  output  2  bit0 = parity error, bit1 = stop-bit error
BYTE_READY  output  1  one-cycle pulse: BYTE_READ/BYTE_ERROR_CODE valid
RxStateCode  output  3  current state, for debug LEDs

Behaviour:
- Reset (async, active-high): state IDLE; BYTE_READ=8'h00, BYTE_ERROR_CODE=2'b00, BYTE_READY=0; shift register, bit counter, timeout counter and sync flops cleared; sync flops reset to 1 (idle-high line).
- Input conditioning: both lines pass through 2-FF synchronisers; a third register on clock detects falling edge (prev=1, curr=0). Pin edge to internal edge strobe: 3 CLK cycles. Data is sampled from its synchronised copy on the edge strobe.
- States (3-bit): IDLE=0, DATA=1, PARITY=2, STOP=3, DONE=4.
- IDLE: on edge strobe with READ_ENABLE=1 and data=0 (start bit) -> DATA, bit counter=0, timeout counter=0. Start bit of 1, or READ_ENABLE=0: ignore edge, stay IDLE.
- DATA: on each edge shift data into bit[counter] (LSB first); after 8th bit -> PARITY.
- PARITY: on edge latch parity bit -> STOP.
- STOP: on edge latch stop bit -> DONE.
- DONE (one cycle): load BYTE_READ from shift register; BYTE_ERROR_CODE[0]=1 if XOR(data, parity)!=1; [1]=1 if stop bit=0; BYTE_READY=1 for this cycle only; -> IDLE.
- BYTE_READY latency: exactly 1 CLK after the stop-bit edge strobe. BYTE_READ/BYTE_ERROR_CODE hold until the next DONE.
- Frames with errors are still reported (BYTE_READY pulses); the master decides.
- Timeout: in DATA/PARITY/STOP counter increments each cycle, clears on edge strobe; reaching TIMEOUT_CYCLES -> IDLE without BYTE_READY, outputs unchanged.
- READ_ENABLE falling mid-frame does not abort; the frame completes. It only gates frame start.
- A stop-bit edge and a READ_ENABLE change in the same cycle: stop edge processed normally.
- Reset mid-frame: immediate return to IDLE; the partial frame is discarded. The next start bit after reset is accepted.
- Back-to-back frames: IDLE accepts a start edge on the cycle after DONE.

Decomposition:
- Shared package mouse_pkg: state encodings (RX_IDLE..RX_DONE), error-code constants (ERR_NONE=2'b00, ERR_PARITY=2'b01, ERR_STOP=2'b10), PS/2 command/response bytes (FA, AA, F4, FF) shared with the master and transmitter.
- One sub-module: ps2_edge_sync. It contains the 2-FF synchronisers for both lines and the clock falling-edge strobe, and is reused by the transmitter.

Test Plan:
- READ_ENABLE=1, frame 0xFA, parity 1, stop 1 at 10 kHz PS/2 clock -> single BYTE_READY pulse, BYTE_READ=8'hFA, ERROR=2'b00, 1 CLK after last-edge strobe.
- Frames 0xAA (p=1), then 0x00 (p=1) back-to-back -> two pulses, values 8'hAA then 8'h00, ERROR=2'b00 each.
- Frame 0xFA with parity 0 -> BYTE_READ=8'hFA, ERROR=2'b01. Frame 0xF4 (p=0) with stop 0 -> ERROR=2'b10.
- Clock stops after 4 data bits; wait TIMEOUT_CYCLES+10 -> no BYTE_READY, state IDLE. Then full 0x00 frame -> one pulse, 8'h00, no stale bits.
- READ_ENABLE=0, full 0xFA frame -> no BYTE_READY, outputs keep reset values. READ_ENABLE dropped after the start bit -> frame completes with a pulse.
- RESET asserted after 5 data bits of 0xFA -> all outputs 0 immediately. Next clean 0xAA frame -> BYTE_READ=8'hAA, ERROR=2'b00.
